// File: rtl/dct8x8_quant_zigzag_if.sv
// Stream and table-port bundle for the 8x8 quantiser / zig-zag serialiser.
// master: upstream DCT, downstream entropy coder and table writer; slave: the quantiser.
interface dct8x8_quant_zigzag_if #(
    parameter int unsigned IN_W    = 32,
    parameter int unsigned RECIP_W = 16,
    parameter int unsigned OUT_W   = 12
);
    // Block input, row-major coefficients
    logic                     in_valid;
    logic                     in_ready;
    logic [64*IN_W-1:0]       in_data;
    // Serial zig-zag output
    logic                     out_valid;
    logic                     out_ready;
    logic signed [OUT_W-1:0]  out_data;
    logic [5:0]               out_index;
    logic                     out_last;
    // Reciprocal table write port
    logic                     tbl_we;
    logic [5:0]               tbl_addr;
    logic [RECIP_W-1:0]       tbl_data;
    logic                     tbl_ready;

    modport master (
        output in_valid, in_data, out_ready, tbl_we, tbl_addr, tbl_data,
        input  in_ready, out_valid, out_data, out_index, out_last, tbl_ready
    );

    modport slave (
        input  in_valid, in_data, out_ready, tbl_we, tbl_addr, tbl_data,
        output in_ready, out_valid, out_data, out_index, out_last, tbl_ready
    );
endinterface

// File: rtl/dct8x8_quant_zigzag.sv
// Quantises one 8x8 block of DCT coefficients with a programmable reciprocal table and
// streams the 64 results in JPEG zig-zag order, one per beat.
module dct8x8_quant_zigzag #(
    parameter int unsigned IN_W    = 32,
    parameter int unsigned FRAC_W  = 0,
    parameter int unsigned RECIP_W = 16,
    parameter int unsigned OUT_W   = 12
) (
    input logic                  clk,
    input logic                  rst_n,
    dct8x8_quant_zigzag_if.slave bus
);
    localparam int unsigned SH = 16 + FRAC_W;
    // One spare bit so the rounding add can never wrap
    localparam int unsigned PW = IN_W + RECIP_W + 1;
    localparam logic [PW-1:0] HALF = PW'(1) << (SH - 1);
    localparam logic [PW-1:0] LIM  = PW'(1) << (OUT_W - 1);

    // Beat number -> row-major position
    localparam logic [5:0] ZZ [64] = '{
         0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
        12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
        35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
        58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63
    };

    // JPEG Q50 luminance quantiser, row-major
    localparam int unsigned Q50 [64] = '{
        16,  11,  10,  16,  24,  40,  51,  61,
        12,  12,  14,  19,  26,  58,  60,  55,
        14,  13,  16,  24,  40,  57,  69,  56,
        14,  17,  22,  29,  51,  87,  80,  62,
        18,  22,  37,  56,  68, 109, 103,  77,
        24,  35,  55,  64,  81, 104, 113,  92,
        49,  64,  78,  87, 103, 121, 120, 101,
        72,  92,  95,  98, 112, 100, 103,  99
    };

    // round(2^16 / q), capped to the table entry width
    function automatic logic [RECIP_W-1:0] recip(input int unsigned q);
        longint unsigned r;
        longint unsigned rmax;
        r    = (64'd65536 + 64'(q / 2)) / 64'(q);
        rmax = (64'd1 << RECIP_W) - 64'd1;
        if (r > rmax) r = rmax;
        return r[RECIP_W-1:0];
    endfunction

    typedef enum logic [0:0] {StIdle, StStream} state_e;

    state_e                  state_q;
    logic [IN_W-1:0]         buf_q [64];
    logic [RECIP_W-1:0]      tbl_q [64];
    logic                    out_valid_q;
    logic                    out_last_q;
    logic [5:0]              out_index_q;
    logic signed [OUT_W-1:0] out_data_q;

    logic                    idle;
    logic [5:0]              beat_nxt;
    logic [5:0]              pos;
    logic [IN_W-1:0]         coef;
    logic                    neg;
    logic [RECIP_W-1:0]      recip_sel;
    logic [IN_W-1:0]         mag;
    logic [PW-1:0]           prod;
    logic [PW-1:0]           rnd;
    logic [OUT_W-1:0]        quant;

    // Shared quantiser: computes the beat that will be loaded into the output register next
    always_comb begin
        idle     = (state_q == StIdle);
        beat_nxt = out_index_q + 6'd1;
        // In idle the next beat is beat 0, taken straight from the bus so it is ready next cycle
        pos      = idle ? ZZ[0] : ZZ[beat_nxt];
        coef     = idle ? bus.in_data[IN_W-1:0] : buf_q[pos];
        // Bypass a table write landing in the accept cycle so it applies to this block
        recip_sel = (idle && bus.tbl_we && (bus.tbl_addr == pos)) ? bus.tbl_data : tbl_q[pos];
        neg      = coef[IN_W-1];
        mag      = neg ? (~coef + 1'b1) : coef;
        prod     = PW'(mag) * PW'(recip_sel);
        rnd      = (prod + HALF) >> SH;
        if (!neg) begin
            quant = (rnd >= LIM) ? {1'b0, {(OUT_W-1){1'b1}}} : rnd[OUT_W-1:0];
        end else begin
            quant = (rnd >= LIM) ? {1'b1, {(OUT_W-1){1'b0}}} : (~rnd[OUT_W-1:0] + 1'b1);
        end
    end

    // Block buffer: captured whole on acceptance, read one coefficient per beat
    always_ff @(posedge clk) begin
        if (idle && bus.in_valid) begin
            for (int i = 0; i < 64; i++) begin
                buf_q[i] <= bus.in_data[i*IN_W +: IN_W];
            end
        end
    end

    // Reciprocal table: resets to Q50, writable only while idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 64; k++) begin
                tbl_q[k] <= recip(Q50[k]);
            end
        end else if (idle && bus.tbl_we) begin
            tbl_q[bus.tbl_addr] <= bus.tbl_data;
        end
    end

    // Control FSM with registered output beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_index_q <= 6'd0;
            out_data_q  <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (bus.in_valid) begin
                        state_q     <= StStream;
                        out_valid_q <= 1'b1;
                        out_last_q  <= 1'b0;
                        out_index_q <= 6'd0;
                        out_data_q  <= quant;
                    end
                end
                StStream: begin
                    if (bus.out_ready) begin
                        if (out_last_q) begin
                            state_q     <= StIdle;
                            out_valid_q <= 1'b0;
                            out_last_q  <= 1'b0;
                            out_index_q <= 6'd0;
                        end else begin
                            out_index_q <= beat_nxt;
                            out_last_q  <= (beat_nxt == 6'd63);
                            out_data_q  <= quant;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.in_ready  = idle;
    assign bus.tbl_ready = idle;
    assign bus.out_valid = out_valid_q;
    assign bus.out_last  = out_last_q;
    assign bus.out_index = out_index_q;
    assign bus.out_data  = out_data_q;

endmodule
